// File: rtl/serial_frame_rx.sv
// Serial byte receiver: start bit, 8 data bits MSB first, stop bit.
// Single clock, async active-low reset, all outputs registered.
module serial_frame_rx #(
    parameter int unsigned BIT_PERIOD   = 106,
    parameter int unsigned SAMPLE_POINT = 53
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_in,
    input  logic       rx_en,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       dsr,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(SAMPLE_POINT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic                line;
    logic                line_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rx_data_d;
    logic                rx_valid_d;
    logic                dsr_d;
    logic                framing_error_d;
    logic                overrun_error_d;
    logic                busy_d;
    logic                load_c;
    logic                ovr_set_c;

    assign line = sync_q[1];

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        shift_d         = shift_q;
        framing_error_d = 1'b0;
        load_c          = 1'b0;
        ovr_set_c       = 1'b0;

        if (!rx_en) begin
            state_d = R_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (line_prev_q && !line) begin
                        state_d = R_START;
                        cnt_d   = '0;
                    end
                end
                R_START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = line ? R_IDLE : R_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {shift_q[DATA_W-2:0], line};
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(7)) begin
                            state_d = R_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        state_d = R_IDLE;
                        if (!line) begin
                            framing_error_d = 1'b1;
                        end else if (rx_valid) begin
                            ovr_set_c = 1'b1;
                        end else begin
                            load_c = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = R_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // A load beats a coincident acknowledge
        rx_data_d  = load_c ? shift_q : rx_data;
        rx_valid_d = load_c ? 1'b1 : (rx_ack ? 1'b0 : rx_valid);
        overrun_error_d = ovr_set_c ? 1'b1 : (rx_ack ? 1'b0 : overrun_error);
        dsr_d  = rx_en & ~rx_valid;
        busy_d = (state_d != R_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= R_IDLE;
            sync_q        <= 2'b11;
            line_prev_q   <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            dsr           <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[0], data_in};
            line_prev_q   <= line;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_data       <= rx_data_d;
            rx_valid      <= rx_valid_d;
            dsr           <= dsr_d;
            framing_error <= framing_error_d;
            overrun_error <= overrun_error_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame-level reference model, directed and random frames.
module tb_serial_frame_rx;

    localparam int BP  = 106;
    localparam int SP  = 53;
    localparam int LAT = 2 + SP + 9 * BP + 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       data_in;
    logic       rx_en;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       dsr;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference model state
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;

    // Observations collected while a frame is on the line
    int   rise_cyc;
    int   fe_cyc;
    int   fe_cnt;
    logic dsr_at_lat;
    logic dsr_after_lat;

    serial_frame_rx #(.BIT_PERIOD(BP), .SAMPLE_POINT(SP)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .rx_en         (rx_en),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .dsr           (dsr),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        data_in = 1'b1;
        repeat (n) tick();
    endtask

    // Model of frame completion, optionally with an acknowledge at the same instant
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_same);
        logic ovr_set;
        logic load;
        ovr_set = stop && m_valid;
        load    = stop && !m_valid;
        if (load) m_data = d;
        if (ovr_set) m_ovr = 1'b1;
        else if (ack_same) m_ovr = 1'b0;
        if (load) m_valid = 1'b1;
        else if (ack_same) m_valid = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        tick();
    endtask

    // Drives one frame from the pin; cycle i+1 is observed after the (i+1)th edge past the falling edge
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_edge,
                              input int abort_at, input logic abort_rst);
        int   b;
        logic pv;
        rise_cyc = -1;
        fe_cyc   = -1;
        fe_cnt   = 0;
        pv       = rx_valid;
        for (int i = 0; i < 10 * BP; i++) begin
            if (i == abort_at) begin
                if (abort_rst) reset_n = 1'b0;
                else rx_en = 1'b0;
                break;
            end
            b = i / BP;
            if (b == 0) data_in = 1'b0;
            else if (b == 9) data_in = stop;
            else data_in = d[8-b];
            rx_ack = (i + 1 == ack_edge);
            tick();
            if (rx_valid && !pv && rise_cyc < 0) rise_cyc = i + 1;
            pv = rx_valid;
            if (framing_error) begin
                fe_cnt++;
                if (fe_cyc < 0) fe_cyc = i + 1;
            end
            if (i + 1 == LAT) dsr_at_lat = dsr;
            if (i + 1 == LAT + 1) dsr_after_lat = dsr;
        end
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_en   = 1'b0;
        rx_ack  = 1'b0;
        data_in = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        repeat (3) tick();
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_tests++; if (dsr !== 1'b0) begin n_fail++; $display("FAIL reset_dsr: got %b want 0", dsr); end
        n_tests++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_framing: got %b want 0", framing_error); end
        n_tests++; if (overrun_error !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_error); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        rx_en   = 1'b1;
        idle(5);
        n_tests++; if (dsr !== 1'b1) begin n_fail++; $display("FAIL ready_dsr: got %b want 1", dsr); end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
        model_frame(8'hA5, 1'b1, 1'b0);
        idle(5);
        n_tests++; if (rise_cyc !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc, LAT); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
        n_tests++; if (dsr_at_lat !== 1'b1) begin n_fail++; $display("FAIL basic_dsr_at_load: got %b want 1", dsr_at_lat); end
        n_tests++; if (dsr_after_lat !== 1'b0) begin n_fail++; $display("FAIL basic_dsr_after: got %b want 0", dsr_after_lat); end
        n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL basic_framing: got %0d pulses want 0", fe_cnt); end
        do_ack();
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid: got %b want 0", rx_valid); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ack_data_held: got %h want a5", rx_data); end
    endtask

    task automatic test_false_start();
        logic busy_seen;
        logic fe_seen;
        busy_seen = 1'b0;
        fe_seen   = 1'b0;
        data_in   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_seen |= busy;
            fe_seen   |= framing_error;
        end
        data_in = 1'b1;
        for (int i = 0; i < SP + 20; i++) begin
            tick();
            busy_seen |= busy;
            fe_seen   |= framing_error;
        end
        n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_pulse: got %b want 1", busy_seen); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got busy %b want 0", busy); end
        n_tests++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL false_start_valid: got %b want %b", rx_valid, m_valid); end
        n_tests++; if (fe_seen !== 1'b0) begin n_fail++; $display("FAIL false_start_framing: got %b want 0", fe_seen); end
        n_tests++; if (overrun_error !== m_ovr) begin n_fail++; $display("FAIL false_start_overrun: got %b want %b", overrun_error, m_ovr); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle(5);
        n_tests++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL framing_pulse_count: got %0d want 1", fe_cnt); end
        n_tests++; if (fe_cyc !== LAT) begin n_fail++; $display("FAIL framing_pulse_cycle: got %0d want %0d", fe_cyc, LAT); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL framing_valid: got %b want 0", rx_valid); end
        n_tests++; if (rx_data !== m_data) begin n_fail++; $display("FAIL framing_data_kept: got %h want %h", rx_data, m_data); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        model_frame(8'h11, 1'b1, 1'b0);
        idle(5);
        send_frame(8'h22, 1'b1, -1, -1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        n_tests++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_data: got %h want 11", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
        n_tests++; if (overrun_error !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun_error); end
        do_ack();
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_valid: got %b want 0", rx_valid); end
        n_tests++; if (overrun_error !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_overrun: got %b want 0", overrun_error); end
    endtask

    task automatic test_ack_collision();
        send_frame(8'h7E, 1'b1, LAT, -1, 1'b0);
        model_frame(8'h7E, 1'b1, 1'b1);
        idle(5);
        n_tests++; if (rise_cyc !== LAT) begin n_fail++; $display("FAIL collide_latency: got %0d want %0d", rise_cyc, LAT); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL collide_valid: got %b want 1", rx_valid); end
        n_tests++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL collide_data: got %h want 7e", rx_data); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'hC3, 1'b1, -1, 4 * BP + 50, 1'b1);
        data_in = 1'b1;
        #1;
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h want 00", rx_data); end
        n_tests++; if ({dsr, framing_error, overrun_error, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_flags: got %b want 0000", {dsr, framing_error, overrun_error, busy});
        end
        repeat (3) tick();
        n_tests++; if ({rx_valid, dsr, framing_error, overrun_error, busy} !== 5'b00000) begin
            n_fail++; $display("FAIL midreset_hold: got %b want 00000", {rx_valid, dsr, framing_error, overrun_error, busy});
        end
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        reset_n = 1'b1;
        idle(5);
        send_frame(8'hFF, 1'b1, -1, -1, 1'b0);
        model_frame(8'hFF, 1'b1, 1'b0);
        idle(5);
        n_tests++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL postreset_data: got %h want ff", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL postreset_valid: got %b want 1", rx_valid); end
        n_tests++; if (rise_cyc !== LAT) begin n_fail++; $display("FAIL postreset_latency: got %0d want %0d", rise_cyc, LAT); end
        do_ack();
    endtask

    task automatic test_abort();
        logic fe_seen;
        fe_seen = 1'b0;
        send_frame(8'h5A, 1'b1, -1, 4 * BP + 30, 1'b0);
        data_in = 1'b1;
        repeat (2) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (dsr !== 1'b0) begin n_fail++; $display("FAIL abort_dsr: got %b want 0", dsr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            fe_seen |= framing_error;
        end
        rx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            fe_seen |= framing_error;
        end
        n_tests++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL abort_valid: got %b want %b", rx_valid, m_valid); end
        n_tests++; if (rx_data !== m_data) begin n_fail++; $display("FAIL abort_data: got %h want %h", rx_data, m_data); end
        n_tests++; if ({fe_seen, overrun_error} !== {1'b0, m_ovr}) begin
            n_fail++; $display("FAIL abort_errors: got %b want %b", {fe_seen, overrun_error}, {1'b0, m_ovr});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        int         exp_rise;
        int         exp_fe;
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_ack();
            exp_rise = (stop && !m_valid) ? LAT : -1;
            exp_fe   = stop ? 0 : 1;
            send_frame(d, stop, -1, -1, 1'b0);
            model_frame(d, stop, 1'b0);
            idle(int'($urandom_range(3, 20)));
            n_tests++; if (rise_cyc !== exp_rise) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", k, rise_cyc, exp_rise); end
            n_tests++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL rand%0d_framing: got %0d want %0d", k, fe_cnt, exp_fe); end
            n_tests++; if (rx_valid !== m_valid) begin n_fail++; $display("FAIL rand%0d_valid: got %b want %b", k, rx_valid, m_valid); end
            n_tests++; if (rx_data !== m_data) begin n_fail++; $display("FAIL rand%0d_data: got %h want %h", k, rx_data, m_data); end
            n_tests++; if (overrun_error !== m_ovr) begin n_fail++; $display("FAIL rand%0d_overrun: got %b want %b", k, overrun_error, m_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_back_to_back();
        test_ack_collision();
        test_reset_mid();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
